// File: rtl/bp_fpga_host_pkg.sv
// Shared definitions for the FPGA host UART path (RX, TX and their benches).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   bp_fpga_host_uart_rx_state_e : receiver FSM states
//   uart_parity_calc()           : parity bit a transmitter would send for a character
package bp_fpga_host_pkg;

    typedef enum logic [2:0] {
        e_idle   = 3'd0,
        e_start  = 3'd1,
        e_data   = 3'd2,
        e_parity = 3'd3,
        e_stop   = 3'd4
    } bp_fpga_host_uart_rx_state_e;

    // Widest character the UART supports; narrower characters are zero-extended,
    // which leaves the XOR unchanged.
    localparam int unsigned uart_max_data_bits_lp = 9;

    // Even parity: XOR of the data bits. Odd parity: its complement.
    function automatic logic uart_parity_calc(
        input logic [uart_max_data_bits_lp-1:0] data,
        input logic                             odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/bp_fpga_host_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk_i edges from d_i to q_o.
// Backpressure: none; free-running.
//
// Ports:
//   clk_i     in  destination clock
//   reset_n_i in  asynchronous active-low reset; both flops load reset_val_p
//   d_i       in  asynchronous input
//   q_o       out synchronized output
module bp_fpga_host_sync2 #(
    parameter logic reset_val_p = 1'b1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_meta <= reset_val_p;
            r_sync <= reset_val_p;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/bp_fpga_host_uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop into a one-entry output register.
// Latency: v_o / error pulses register on the edge of the last stop-bit sample (rx sync adds 2 cycles).
// Backpressure: valid/yumi; a good character arriving while v_o=1 and no yumi is dropped with overrun_error_o.
//
// Ports:
//   clk_i           in  system clock
//   reset_n_i       in  asynchronous active-low reset
//   rx_i            in  asynchronous serial line, idles high
//   data_o          out received character, LSB = first data bit
//   v_o             out data_o holds an unconsumed character
//   yumi_i          in  consumer takes data_o (only while v_o=1)
//   parity_error_o  out one-cycle pulse: character dropped for bad parity
//   frame_error_o   out one-cycle pulse: character dropped for a low stop bit
//   overrun_error_o out one-cycle pulse: good character dropped, output register full
module bp_fpga_host_uart_rx
    import bp_fpga_host_pkg::*;
#(
    parameter int unsigned clk_per_bit_p = 10416,
    parameter int unsigned data_bits_p   = 8,
    parameter int unsigned parity_bit_p  = 0,
    parameter int unsigned parity_odd_p  = 0,
    parameter int unsigned stop_bits_p   = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   rx_i,
    output logic [data_bits_p-1:0] data_o,
    output logic                   v_o,
    input  logic                   yumi_i,
    output logic                   parity_error_o,
    output logic                   frame_error_o,
    output logic                   overrun_error_o
);

    localparam int unsigned cnt_w_lp = $clog2(clk_per_bit_p);

    // Start bit is re-checked half a bit after the edge; every later sample is a
    // whole bit after the previous one, so all samples land mid-bit.
    localparam logic [cnt_w_lp-1:0] cnt_half_lp = cnt_w_lp'(clk_per_bit_p / 2 - 1);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(clk_per_bit_p - 1);
    localparam logic [3:0]          data_last_lp = 4'(data_bits_p - 1);
    localparam logic [3:0]          stop_last_lp = 4'(stop_bits_p - 1);
    localparam logic                parity_odd_lp = (parity_odd_p != 0);

    bp_fpga_host_uart_rx_state_e r_state;
    logic [cnt_w_lp-1:0]         r_cnt;
    logic [3:0]                  r_bit_idx;
    logic [data_bits_p-1:0]      r_shift;
    logic                        r_par_bad;
    logic                        r_frm_bad;
    logic [data_bits_p-1:0]      r_data;
    logic                        r_v;
    logic                        r_parity_error;
    logic                        r_frame_error;
    logic                        r_overrun_error;

    logic                        w_rx;
    logic                        w_sample;
    logic                        w_frm_bad;
    logic                        w_par_exp;
    logic [uart_max_data_bits_lp-1:0] w_par_data;

    bp_fpga_host_sync2 #(
        .reset_val_p (1'b1)
    ) u_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (rx_i),
        .q_o       (w_rx)
    );

    // Mid-bit strobe for the data/parity/stop states.
    assign w_sample   = (r_cnt == cnt_last_lp);
    assign w_par_data = uart_max_data_bits_lp'(r_shift);
    assign w_par_exp  = uart_parity_calc(w_par_data, parity_odd_lp);
    // Frame error accumulated over every stop bit including the current sample.
    assign w_frm_bad  = r_frm_bad | ~w_rx;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state         <= e_idle;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_par_bad       <= 1'b0;
            r_frm_bad       <= 1'b0;
            r_data          <= '0;
            r_v             <= 1'b0;
            r_parity_error  <= 1'b0;
            r_frame_error   <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            r_parity_error  <= 1'b0;
            r_frame_error   <= 1'b0;
            r_overrun_error <= 1'b0;

            // Consumption; a load later in this block overrides it so that a
            // same-cycle yumi and new character leave v_o set with the new data.
            if (yumi_i) begin
                r_v <= 1'b0;
            end

            case (r_state)
                e_idle: begin
                    if (!w_rx) begin
                        r_state <= e_start;
                        r_cnt   <= '0;
                    end
                end

                e_start: begin
                    if (r_cnt == cnt_half_lp) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_par_bad <= 1'b0;
                        r_frm_bad <= 1'b0;
                        // A line that is high again by mid start bit was noise.
                        r_state   <= w_rx ? e_idle : e_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                e_data: begin
                    if (w_sample) begin
                        r_cnt   <= '0;
                        // Shift in from the top so the first bit ends up in bit 0.
                        r_shift <= {w_rx, r_shift[data_bits_p-1:1]};
                        if (r_bit_idx == data_last_lp) begin
                            r_bit_idx <= '0;
                            r_state   <= (parity_bit_p != 0) ? e_parity : e_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                e_parity: begin
                    if (w_sample) begin
                        r_cnt     <= '0;
                        r_par_bad <= (w_rx != w_par_exp);
                        r_state   <= e_stop;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                e_stop: begin
                    if (w_sample) begin
                        r_cnt <= '0;
                        if (r_bit_idx == stop_last_lp) begin
                            // Return to idle mid stop bit so a back-to-back
                            // start edge is not missed.
                            r_state   <= e_idle;
                            r_bit_idx <= '0;
                            if (w_frm_bad) begin
                                r_frame_error <= 1'b1;
                            end else if (r_par_bad) begin
                                r_parity_error <= 1'b1;
                            end else if (r_v && !yumi_i) begin
                                r_overrun_error <= 1'b1;
                            end else begin
                                r_data <= r_shift;
                                r_v    <= 1'b1;
                            end
                        end else begin
                            r_frm_bad <= w_frm_bad;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= e_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign data_o          = r_data;
    assign v_o             = r_v;
    assign parity_error_o  = r_parity_error;
    assign frame_error_o   = r_frame_error;
    assign overrun_error_o = r_overrun_error;

endmodule

// File: tb/tb_bp_fpga_host_uart_rx.sv
// Bench for bp_fpga_host_uart_rx: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
// Latency: a frame whose start edge is driven just after edge N completes on edge N+3+8+nbits*16.
// Backpressure: yumi driven by the directed sequence; the model applies the drop/overrun rules.
module tb_bp_fpga_host_uart_rx;
    import bp_fpga_host_pkg::*;

    localparam int C    = 16;
    localparam int H    = C / 2;
    localparam int D    = 8;
    localparam int NDUT = 3;

    typedef struct {
        int       dut;
        int       due;
        bit [7:0] data;
        bit       pe;
        bit       fe;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NDUT-1:0] rx;
    logic [NDUT-1:0] yumi;
    logic [7:0]      dout [NDUT];
    logic [NDUT-1:0] v_o;
    logic [NDUT-1:0] pe_o;
    logic [NDUT-1:0] fe_o;
    logic [NDUT-1:0] oe_o;

    int cyc = 0;
    int nchk = 0;
    int npass = 0;

    // model state
    ev_t      evq [$];
    bit       m_v    [NDUT];
    bit [7:0] m_data [NDUT];
    bit       m_pe   [NDUT];
    bit       m_fe   [NDUT];
    bit       m_oe   [NDUT];
    bit       m_done;
    bit       m_load;
    ev_t      m_ev;

    // observed pulse counts and v_o rise time of instance 0
    int pe_cnt [NDUT];
    int fe_cnt [NDUT];
    int oe_cnt [NDUT];
    int v_rise;
    bit v_prev0;

    always #5 clk = ~clk;

    bp_fpga_host_uart_rx #(.clk_per_bit_p(C), .data_bits_p(D), .parity_bit_p(0),
                           .parity_odd_p(0), .stop_bits_p(1)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .rx_i(rx[0]), .data_o(dout[0]), .v_o(v_o[0]),
        .yumi_i(yumi[0]), .parity_error_o(pe_o[0]), .frame_error_o(fe_o[0]),
        .overrun_error_o(oe_o[0]));

    bp_fpga_host_uart_rx #(.clk_per_bit_p(C), .data_bits_p(D), .parity_bit_p(1),
                           .parity_odd_p(0), .stop_bits_p(1)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .rx_i(rx[1]), .data_o(dout[1]), .v_o(v_o[1]),
        .yumi_i(yumi[1]), .parity_error_o(pe_o[1]), .frame_error_o(fe_o[1]),
        .overrun_error_o(oe_o[1]));

    bp_fpga_host_uart_rx #(.clk_per_bit_p(C), .data_bits_p(D), .parity_bit_p(0),
                           .parity_odd_p(0), .stop_bits_p(2)) u_dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .rx_i(rx[2]), .data_o(dout[2]), .v_o(v_o[2]),
        .yumi_i(yumi[2]), .parity_error_o(pe_o[2]), .frame_error_o(fe_o[2]),
        .overrun_error_o(oe_o[2]));

    function automatic int par_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int stops_of(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Character-level model: each sent frame is a scheduled completion event;
    // at its edge the drop priority and the output register rules are applied.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                m_v[d] = 1'b0; m_data[d] = 8'h00;
                m_pe[d] = 1'b0; m_fe[d] = 1'b0; m_oe[d] = 1'b0;
            end
            evq.delete();
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                m_pe[d] = 1'b0; m_fe[d] = 1'b0; m_oe[d] = 1'b0;
                m_done = 1'b0;
                m_load = 1'b0;
                for (int k = 0; k < evq.size(); k++) begin
                    if (evq[k].dut == d && evq[k].due == cyc + 1) begin
                        m_ev = evq[k];
                        m_done = 1'b1;
                    end
                end
                if (m_done) begin
                    if (m_ev.fe)                  m_fe[d] = 1'b1;
                    else if (m_ev.pe)             m_pe[d] = 1'b1;
                    else if (m_v[d] && !yumi[d])  m_oe[d] = 1'b1;
                    else                          m_load = 1'b1;
                end
                if (m_load) begin
                    m_v[d] = 1'b1;
                    m_data[d] = m_ev.data;
                end else if (yumi[d]) begin
                    m_v[d] = 1'b0;
                end
            end
            for (int k = evq.size() - 1; k >= 0; k--) begin
                if (evq[k].due <= cyc + 1) evq.delete(k);
            end
        end
    end

    // Per-cycle compare against the model, plus pulse/rise bookkeeping.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d_v", d),       32'(v_o[d]),  32'(m_v[d]));
            check($sformatf("d%0d_data", d),    32'(dout[d]), 32'(m_data[d]));
            check($sformatf("d%0d_parerr", d),  32'(pe_o[d]), 32'(m_pe[d]));
            check($sformatf("d%0d_frmerr", d),  32'(fe_o[d]), 32'(m_fe[d]));
            check($sformatf("d%0d_ovrerr", d),  32'(oe_o[d]), 32'(m_oe[d]));
            if (pe_o[d] === 1'b1) pe_cnt[d]++;
            if (fe_o[d] === 1'b1) fe_cnt[d]++;
            if (oe_o[d] === 1'b1) oe_cnt[d]++;
        end
        if (v_o[0] === 1'b1 && !v_prev0 && v_rise < 0) v_rise = cyc;
        v_prev0 = (v_o[0] === 1'b1);
    end

    // All drivers are entered and left 2 time units after a rising edge.
    task automatic wait_bit();
        repeat (C) @(posedge clk);
        #2;
    endtask

    task automatic send_char(input int d, input logic [7:0] data, input logic par,
                             input logic [1:0] stops);
        int  p  = par_of(d);
        int  s  = stops_of(d);
        int  n0 = cyc;
        ev_t e;
        e.dut  = d;
        e.due  = n0 + 3 + H + (D + p + s) * C;
        e.data = data;
        e.pe   = (p != 0) && (par != (^data));
        e.fe   = (stops[0] == 1'b0) || ((s == 2) && (stops[1] == 1'b0));
        evq.push_back(e);
        rx[d] = 1'b0;
        wait_bit();
        for (int i = 0; i < D; i++) begin
            rx[d] = data[i];
            wait_bit();
        end
        if (p != 0) begin
            rx[d] = par;
            wait_bit();
        end
        for (int j = 0; j < s; j++) begin
            rx[d] = stops[j];
            wait_bit();
        end
        rx[d] = 1'b1;
    endtask

    task automatic pulse_yumi(input int d);
        yumi[d] = 1'b1;
        @(posedge clk);
        #2;
        yumi[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n  = 1'b0;
        rx     = '1;
        yumi   = '0;
        v_rise = -1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_v0", 32'(v_o[0]), 32'd0);
        check("reset_data0", 32'(dout[0]), 32'd0);
        check("reset_errs", 32'({pe_o, fe_o, oe_o}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // 8N1 0xA5: v_o must first be seen after edge N+155
        n0 = cyc;
        v_rise = -1;
        send_char(0, 8'hA5, 1'b0, 2'b11);
        check("a5_v_rise_cycle", 32'(v_rise), 32'(n0 + 155));
        check("a5_data", 32'(dout[0]), 32'h0000_00A5);
        repeat (10) @(posedge clk);
        #2;
        check("a5_v_held", 32'(v_o[0]), 32'd1);
        pulse_yumi(0);
        check("a5_v_after_yumi", 32'(v_o[0]), 32'd0);

        // 8E1 0x03: parity bit 1 is wrong, 0 is right
        pe_cnt[1] = 0;
        send_char(1, 8'h03, 1'b1, 2'b11);
        repeat (4) @(posedge clk);
        #2;
        check("par_bad_pulses", 32'(pe_cnt[1]), 32'd1);
        check("par_bad_no_v", 32'(v_o[1]), 32'd0);
        send_char(1, 8'h03, 1'b0, 2'b11);
        check("par_good_data", 32'(dout[1]), 32'h0000_0003);
        check("par_good_v", 32'(v_o[1]), 32'd1);
        pulse_yumi(1);

        // 8N2 0x5A with second stop bit low, then a clean frame
        fe_cnt[2] = 0;
        send_char(2, 8'h5A, 1'b0, 2'b01);
        repeat (12) @(posedge clk);
        #2;
        check("frm_pulses", 32'(fe_cnt[2]), 32'd1);
        check("frm_no_v", 32'(v_o[2]), 32'd0);
        send_char(2, 8'h5A, 1'b0, 2'b11);
        check("frm_next_data", 32'(dout[2]), 32'h0000_005A);
        pulse_yumi(2);

        // 4-cycle low glitch on instance 0
        rx[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rx[0] = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("glitch_no_v", 32'(v_o[0]), 32'd0);
        check("glitch_idle", 32'(u_dut0.r_state), 32'(e_idle));

        // back-to-back without yumi: second character is an overrun
        oe_cnt[0] = 0;
        send_char(0, 8'h11, 1'b0, 2'b11);
        send_char(0, 8'h22, 1'b0, 2'b11);
        repeat (2) @(posedge clk);
        #2;
        check("ovr_pulses", 32'(oe_cnt[0]), 32'd1);
        check("ovr_keeps_old", 32'(dout[0]), 32'h0000_0011);
        pulse_yumi(0);

        // again, with yumi in the second completion cycle (edge N+155)
        send_char(0, 8'h11, 1'b0, 2'b11);
        fork
            send_char(0, 8'h22, 1'b0, 2'b11);
            begin
                repeat (154) @(posedge clk);
                #2;
                pulse_yumi(0);
            end
        join
        repeat (2) @(posedge clk);
        #2;
        check("yumi_load_data", 32'(dout[0]), 32'h0000_0022);
        check("yumi_load_v", 32'(v_o[0]), 32'd1);
        check("yumi_load_no_ovr", 32'(oe_cnt[0]), 32'd1);

        // reset during data bit 3 with a character still pending
        rx[0] = 1'b0;
        wait_bit();
        rx[0] = 1'b1;
        repeat (3) wait_bit();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_v", 32'(v_o[0]), 32'd0);
        check("rst_mid_data", 32'(dout[0]), 32'd0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_after_idle", 32'(u_dut0.r_state), 32'(e_idle));
        send_char(0, 8'hFF, 1'b0, 2'b11);
        check("rst_ff_data", 32'(dout[0]), 32'h0000_00FF);
        check("rst_ff_v", 32'(v_o[0]), 32'd1);
        pulse_yumi(0);
        repeat (4) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
